cpu_param: RTL
==============

# cpu_param

Parametrised accumulator CPU that succeeds the fixed 8-bit/16-word core. Data width and memory depth are generics. Execution uses variable-length microcode: each instruction ends as soon as its last micro-step completes, instead of padding to a fixed step count. The block adds logic ops, JNZ and HLT, plus a valid/ready output handshake with backpressure. It sits in the top-level user design: the loader drives the prog port and the UART transmitter consumes out_data.

## Interface
- DATA_W, 8: data/instruction word width; must satisfy DATA_W >= 4 + ADDR_W.
- ADDR_W, 4: address width; RAM depth = 2**ADDR_W words.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- prog  in  1  program mode; writes RAM and holds the core idle.
- prog_addr  in  ADDR_W  RAM write address in program mode.
- prog_data  in  DATA_W  RAM write data in program mode.
- out_data  out  DATA_W  registered output value.
- out_valid  out  1  out_data holds an unaccepted value.
- out_ready  in  1  consumer accepts out_data.
- halted  out  1  core has executed HLT.

## Operation
- Instruction word: opcode = bits [DATA_W-1:DATA_W-4]; operand = bits [ADDR_W-1:0]; bits in between are ignored.
- Opcodes:
  - 0 NOP
  - 1 LDA
  - 2 ADD
  - 3 OUT
  - 4 JMP
  - 5 STA
  - 6 LDI
  - 7 SUB
  - 8 JMZ
  - 9 CMP
  - A JMC
  - B AND
  - C OR
  - D XOR
  - E JNZ
  - F HLT
- Registers: PC, MAR (ADDR_W bits); IR, A, B (DATA_W bits); Z and C flags.
- States: F0, F1, E0, E1, E2, OW, HLT.
- Fetch, common to all opcodes:
  - F0: MAR <= PC.
  - F1: IR <= RAM[MAR]; PC <= PC+1, wrapping 2**ADDR_W-1 -> 0.
  - Then E0.
- NOP: E0 -> F0.
- LDI: E0: A <= zero-extended operand -> F0.
- JMP: E0: PC <= operand. JMZ jumps only if Z=1; JNZ only if Z=0; JMC only if C=1. Not taken leaves PC unchanged. All -> F0.
- LDA: E0: MAR <= operand; E1: A <= RAM[MAR] -> F0.
- STA: E0: MAR <= operand; E1: RAM[MAR] <= A -> F0.
- ADD/SUB/AND/OR/XOR/CMP: E0: MAR <= operand; E1: B <= RAM[MAR]; E2: compute R, update flags -> F0.
  - A <= R for all of these except CMP, which leaves A unchanged.
- ALU arithmetic is (DATA_W+1)-bit: ADD R = {0,A}+{0,B}; SUB/CMP R = {0,A}-{0,B}.
  - C <= R[DATA_W] (ADD carry; SUB/CMP borrow, i.e. A<B).
  - Z <= (R[DATA_W-1:0] == 0).
  - AND/OR/XOR: Z from result; C <= 0.
- Flags change only in E2 of ALU ops.
- OUT: E0: out_data <= A, out_valid <= 1 -> OW. OW: when out_ready=1, out_valid <= 0 -> F0; otherwise stay in OW with all state frozen.
- HLT: E0: halted <= 1 -> HLT. HLT is left only by reset or prog.
- Program mode (prog=1):
  - RAM[prog_addr] <= prog_data every cycle, regardless of rst_n.
  - Core forced to F0 with PC=0, halted=0, out_valid=0.
  - A, B, IR and flags are held.
  - Core RAM writes (STA) are suppressed.
- RAM has no reset; contents survive rst_n.

## Timing
- Reset (rst_n=0 at posedge):
  - PC, MAR, IR, A, B, Z, C = 0.
  - out_data=0, out_valid=0, halted=0.
  - State = F0.
- Priority: rst_n over prog over normal execution.
- Cycles per instruction:
  - NOP/LDI/JMP/JMZ/JNZ/JMC: 3.
  - LDA/STA: 4.
  - ADD/SUB/AND/OR/XOR/CMP: 5.
  - OUT: 3 plus cycles in OW (minimum 1).
  - HLT: 3 to reach HLT.
- out_valid rises on the edge ending E0 and stays 1 with out_data stable until the edge where out_valid&&out_ready. It is 0 the cycle after.
- out_ready may be high before out_valid; acceptance needs both high at the same edge.
- Reset or prog asserted during OW: out_valid=0 on the next cycle and the pending value is dropped.
- Reset mid-instruction: the instruction is aborted; a partial STA never writes, because the write occurs only in E1.
- Flags written in E2 are visible to a conditional jump in the immediately following instruction.

## Test plan
- Basic program (cycle 0 = first cycle with rst_n=1, prog=0):
  - Stimulus: RAM = {0x65, 0x2E, 0x30, 0xF0}, RAM[14]=0x03, out_ready=1.
  - Response: out_valid=1 with out_data=0x08 in cycle 11; out_valid=0 in cycle 12; halted=1 from cycle 15.
- Backpressure:
  - Stimulus: same program with out_ready=0 for 10 cycles after out_valid rises.
  - Response: out_valid and out_data=0x08 held 10 cycles; PC frozen at 3; transfer on first out_ready=1 edge; halted rises 4 cycles later.
- Borrow and compare:
  - SUB with A=0x03, RAM operand 0x05 -> A=0xFE, C=1, Z=0; following JMC 9 lands at PC=9.
  - CMP with equal values -> Z=1, A unchanged; JMZ taken; JNZ not taken (PC = next address).
- Logic ops:
  - A=0xF0: XOR 0xF0 -> A=0x00, Z=1, C=0.
  - OR 0x0F -> A=0x0F, Z=0.
- Wrap and modes:
  - NOP at address 15 (ADDR_W=4) -> next fetch from address 0.
  - prog pulse while halted -> halted=0, PC=0, new RAM content executes.
- Reset during OW: out_valid, PC, A all 0 on the next cycle; RAM contents unchanged.
- Second parameter set: DATA_W=12, ADDR_W=6.
  - LDI 63 then ADD of 0xFC1 -> A=0x000, C=1, Z=1.
  - JMP 63 -> PC=63; next sequential fetch from 0.

Source files
------------

// File: rtl/cpu_param_if.sv
// Loader/consumer-facing bus of the accumulator core: program port and the
// valid/ready output channel, plus the halted status.
interface cpu_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              prog;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              halted;

    modport master (
        output prog, prog_addr, prog_data, out_ready,
        input  out_data, out_valid, halted
    );

    modport slave (
        input  prog, prog_addr, prog_data, out_ready,
        output out_data, out_valid, halted
    );
endinterface

// File: rtl/cpu_param.sv
// Parametrised accumulator CPU with variable-length microcode, logic ops,
// conditional jumps, HLT and a valid/ready output port with backpressure.
module cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cpu_param_if.slave   bus
);
    // state | meaning
    // F0    | MAR <= PC
    // F1    | IR <= RAM[MAR], PC++
    // E0    | decode; single-step ops finish, memory ops latch MAR
    // E1    | memory read/write step
    // E2    | ALU result and flag update
    // OW    | output waiting for out_ready, everything frozen
    // HLT   | halted until reset or prog
    localparam logic [2:0] S_F0  = 3'd0;
    localparam logic [2:0] S_F1  = 3'd1;
    localparam logic [2:0] S_E0  = 3'd2;
    localparam logic [2:0] S_E1  = 3'd3;
    localparam logic [2:0] S_E2  = 3'd4;
    localparam logic [2:0] S_OW  = 3'd5;
    localparam logic [2:0] S_HLT = 3'd6;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JMZ = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_JMC = 4'hA;
    localparam logic [3:0] OP_AND = 4'hB;
    localparam logic [3:0] OP_OR  = 4'hC;
    localparam logic [3:0] OP_XOR = 4'hD;
    localparam logic [3:0] OP_JNZ = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_z;
    logic              r_c;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_halted;

    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_operand_ext;
    logic [DATA_W-1:0] w_mem_rd;
    logic [DATA_W:0]   w_res;
    logic              w_unused_ir;

    assign w_opcode      = r_ir[DATA_W-1 -: 4];
    assign w_operand     = r_ir[ADDR_W-1:0];
    assign w_operand_ext = {{(DATA_W-ADDR_W){1'b0}}, w_operand};
    assign w_mem_rd      = r_mem[r_mar];
    assign w_unused_ir   = ^r_ir;

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.halted    = r_halted;

    // Carry/borrow lands in the extra top bit; logic ops leave it 0 so C clears.
    always_comb begin
        w_res = '0;
        case (w_opcode)
            OP_ADD:         w_res = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB, OP_CMP: w_res = {1'b0, r_a} - {1'b0, r_b};
            OP_AND:         w_res = {1'b0, r_a & r_b};
            OP_OR:          w_res = {1'b0, r_a | r_b};
            OP_XOR:         w_res = {1'b0, r_a ^ r_b};
            default:        w_res = '0;
        endcase
    end

    // RAM has no reset; the loader may write even while rst_n is low.
    always_ff @(posedge clk) begin
        if (bus.prog) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end else if (rst_n && r_state == S_E1 && w_opcode == OP_STA) begin
            r_mem[r_mar] <= r_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_F0;
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else if (bus.prog) begin
            r_state     <= S_F0;
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                S_F0: begin
                    r_mar   <= r_pc;
                    r_state <= S_F1;
                end
                S_F1: begin
                    r_ir    <= w_mem_rd;
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= S_E0;
                end
                S_E0: begin
                    case (w_opcode)
                        OP_NOP: r_state <= S_F0;
                        OP_LDI: begin
                            r_a     <= w_operand_ext;
                            r_state <= S_F0;
                        end
                        OP_JMP: begin
                            r_pc    <= w_operand;
                            r_state <= S_F0;
                        end
                        OP_JMZ: begin
                            if (r_z) r_pc <= w_operand;
                            r_state <= S_F0;
                        end
                        OP_JNZ: begin
                            if (!r_z) r_pc <= w_operand;
                            r_state <= S_F0;
                        end
                        OP_JMC: begin
                            if (r_c) r_pc <= w_operand;
                            r_state <= S_F0;
                        end
                        OP_OUT: begin
                            r_out_data  <= r_a;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OW;
                        end
                        OP_HLT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HLT;
                        end
                        default: begin
                            r_mar   <= w_operand;
                            r_state <= S_E1;
                        end
                    endcase
                end
                S_E1: begin
                    if (w_opcode == OP_LDA) begin
                        r_a     <= w_mem_rd;
                        r_state <= S_F0;
                    end else if (w_opcode == OP_STA) begin
                        r_state <= S_F0;
                    end else begin
                        r_b     <= w_mem_rd;
                        r_state <= S_E2;
                    end
                end
                S_E2: begin
                    if (w_opcode != OP_CMP) r_a <= w_res[DATA_W-1:0];
                    r_c     <= w_res[DATA_W];
                    r_z     <= (w_res[DATA_W-1:0] == '0);
                    r_state <= S_F0;
                end
                S_OW: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_F0;
                    end
                end
                S_HLT:   r_state <= S_HLT;
                default: r_state <= S_F0;
            endcase
        end
    end
endmodule
